// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared iterative divider.
// Owns the divider from grant until result capture or owner cancel, then idles for one cycle.
module div_arbiter (
   input  logic        clk,
   input  logic        rst,
   // requester 0
   input  logic        req0_i,
   input  logic [2:0]  op0_i,
   input  logic [31:0] dividend0_i,
   input  logic [31:0] divisor0_i,
   input  logic [4:0]  waddr0_i,
   input  logic        cancel0_i,
   output logic        gnt0_o,
   output logic        done0_o,
   output logic [31:0] result0_o,
   output logic [4:0]  waddr0_o,
   // requester 1
   input  logic        req1_i,
   input  logic [2:0]  op1_i,
   input  logic [31:0] dividend1_i,
   input  logic [31:0] divisor1_i,
   input  logic [4:0]  waddr1_i,
   input  logic        cancel1_i,
   output logic        gnt1_o,
   output logic        done1_o,
   output logic [31:0] result1_o,
   output logic [4:0]  waddr1_o,
   // divider side
   output logic        div_start_o,
   output logic [2:0]  div_op_o,
   output logic [31:0] div_dividend_o,
   output logic [31:0] div_divisor_o,
   output logic [4:0]  div_waddr_o,
   input  logic        div_ready_i,
   input  logic        div_busy_i,
   input  logic [31:0] div_result_i,
   input  logic [4:0]  div_waddr_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic        owner_reg, owner_next;
   logic        rr_ptr_reg, rr_ptr_next;
   logic [2:0]  op_reg, op_next;
   logic [31:0] dividend_reg, dividend_next;
   logic [31:0] divisor_reg, divisor_next;
   logic [4:0]  waddr_reg, waddr_next;
   logic [1:0]  gnt_reg, gnt_next;
   logic [1:0]  done_reg, done_next;
   logic [1:0]  capture;

   logic [1:0]  req_vec;
   logic [1:0]  cancel_vec;
   logic [1:0]  eligible;
   logic        winner;
   logic [2:0]  op_in       [2];
   logic [31:0] dividend_in [2];
   logic [31:0] divisor_in  [2];
   logic [4:0]  waddr_in    [2];

   assign req_vec        = {req1_i, req0_i};
   assign cancel_vec     = {cancel1_i, cancel0_i};
   assign op_in[0]       = op0_i;
   assign op_in[1]       = op1_i;
   assign dividend_in[0] = dividend0_i;
   assign dividend_in[1] = dividend1_i;
   assign divisor_in[0]  = divisor0_i;
   assign divisor_in[1]  = divisor1_i;
   assign waddr_in[0]    = waddr0_i;
   assign waddr_in[1]    = waddr1_i;

   // A requester flushing itself is not eligible; rr_ptr_reg names the tie winner.
   assign eligible = req_vec & ~cancel_vec;
   assign winner   = eligible[1] & (~eligible[0] | rr_ptr_reg);

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      rr_ptr_next   = rr_ptr_reg;
      op_next       = op_reg;
      dividend_next = dividend_reg;
      divisor_next  = divisor_reg;
      waddr_next    = waddr_reg;
      gnt_next      = 2'b00;
      done_next     = 2'b00;
      capture       = 2'b00;
      case (state_reg)
         IDLE: begin
            if (|eligible) begin
               owner_next       = winner;
               rr_ptr_next      = ~winner;
               op_next          = op_in[winner];
               dividend_next    = dividend_in[winner];
               divisor_next     = divisor_in[winner];
               waddr_next       = waddr_in[winner];
               gnt_next[winner] = 1'b1;
               state_next       = RUN;
            end
         end
         RUN: begin
            // Owner cancel beats a simultaneous ready: the result is dropped.
            if (cancel_vec[owner_reg]) begin
               state_next = RELEASE;
            end else if (div_ready_i) begin
               capture[owner_reg]   = 1'b1;
               done_next[owner_reg] = 1'b1;
               state_next           = RELEASE;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         owner_reg    <= 1'b0;
         rr_ptr_reg   <= 1'b0;
         op_reg       <= '0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         waddr_reg    <= '0;
         gnt_reg      <= '0;
         done_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         rr_ptr_reg   <= rr_ptr_next;
         op_reg       <= op_next;
         dividend_reg <= dividend_next;
         divisor_reg  <= divisor_next;
         waddr_reg    <= waddr_next;
         gnt_reg      <= gnt_next;
         done_reg     <= done_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_wb
         logic [31:0] result_reg;
         logic [4:0]  wb_waddr_reg;
         always_ff @(posedge clk) begin
            if (!rst) begin
               result_reg   <= '0;
               wb_waddr_reg <= '0;
            end else if (capture[gi]) begin
               result_reg   <= div_result_i;
               wb_waddr_reg <= div_waddr_i;
            end
         end
      end
   endgenerate

   assign gnt0_o    = gnt_reg[0];
   assign gnt1_o    = gnt_reg[1];
   assign done0_o   = done_reg[0];
   assign done1_o   = done_reg[1];
   assign result0_o = g_wb[0].result_reg;
   assign result1_o = g_wb[1].result_reg;
   assign waddr0_o  = g_wb[0].wb_waddr_reg;
   assign waddr1_o  = g_wb[1].wb_waddr_reg;

   // Start drops in the ready cycle so the divider never sees a fresh start after finishing.
   assign div_start_o    = (state_reg == RUN) && !div_ready_i && !cancel_vec[owner_reg];
   assign div_op_o       = op_reg;
   assign div_dividend_o = dividend_reg;
   assign div_divisor_o  = divisor_reg;
   assign div_waddr_o    = waddr_reg;
   assign busy_o         = (state_reg != IDLE);

   a_div_idle: assert property (@(posedge clk) disable iff (!rst)
                                (state_reg == IDLE) |-> !div_busy_i);

endmodule
